// File: rtl/condlogic.sv
// -----------------------------------------------------------------------------
// condlogic
//
// Conditional-execution stage of the multicycle core, sitting directly after
// the instruction decoder. It keeps the NZCV status flags and evaluates the
// instruction's condition field against them. It then gates the raw write
// strobes from the decoder/FSM into the architectural write enables.
//
// The condition result is registered (CondExDelayed). The FSM evaluates the
// condition in its decode/execute cycle and raises the write strobes in later
// cycles, so the gate must use the value captured at the end of the
// evaluating cycle.
//
// Optional feature macro: CONDLOGIC_FPU_EN
//   defined   : FPUWrite = FPUW & CondExDelayed (gated like RegWrite)
//   undefined : FPUWrite = 0 and FPUW is ignored (builds without an FPU)
//
// Ports
//   clk       in   1  system clock, rising edge
//   reset     in   1  asynchronous active-low reset; clears flags and
//                     CondExDelayed
//   Cond      in   4  instruction condition field (Instr[31:28])
//   ALUFlags  in   4  {N,Z,C,V} produced by the ALU this cycle
//   FlagW     in   2  flag-write request: [1] = N,Z group, [0] = C,V group
//   PCS       in   1  instruction writes the PC (branch or Rd = R15)
//   NextPC    in   1  unconditional PC+4 update from the FSM (fetch)
//   RegW      in   1  register-file write request
//   MemW      in   1  data-memory write request
//   FPUW      in   1  FPU result write request
//   PCWrite   out  1  PC register enable
//   RegWrite  out  1  register-file write enable
//   MemWrite  out  1  data-memory write enable
//   FPUWrite  out  1  FPU register write enable
//   Flags     out  4  current {N,Z,C,V} register contents
//   CondEx    out  1  combinational condition result for this cycle
// -----------------------------------------------------------------------------
module condlogic (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Cond,
   input  logic [3:0] ALUFlags,
   input  logic [1:0] FlagW,
   input  logic       PCS,
   input  logic       NextPC,
   input  logic       RegW,
   input  logic       MemW,
   input  logic       FPUW,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       FPUWrite,
   output logic [3:0] Flags,
   output logic       CondEx
);

   // Condition-field encodings.
   typedef enum logic [3:0] {
      COND_EQ = 4'b0000,
      COND_NE = 4'b0001,
      COND_CS = 4'b0010,
      COND_CC = 4'b0011,
      COND_MI = 4'b0100,
      COND_PL = 4'b0101,
      COND_VS = 4'b0110,
      COND_VC = 4'b0111,
      COND_HI = 4'b1000,
      COND_LS = 4'b1001,
      COND_GE = 4'b1010,
      COND_LT = 4'b1011,
      COND_GT = 4'b1100,
      COND_LE = 4'b1101,
      COND_AL = 4'b1110,
      COND_NV = 4'b1111
   } cond_e;

   // Evaluate a condition code against an {N,Z,C,V} flag vector.
   // The reserved encoding 1111 never executes.
   function automatic logic cond_eval(input logic [3:0] cond,
                                      input logic [3:0] nzcv);
      logic n, z, c, v;
      logic res;
      {n, z, c, v} = nzcv;
      case (cond_e'(cond))
         COND_EQ: res = z;
         COND_NE: res = ~z;
         COND_CS: res = c;
         COND_CC: res = ~c;
         COND_MI: res = n;
         COND_PL: res = ~n;
         COND_VS: res = v;
         COND_VC: res = ~v;
         COND_HI: res = c & ~z;
         COND_LS: res = ~c | z;
         COND_GE: res = (n == v);
         COND_LT: res = (n != v);
         COND_GT: res = ~z & (n == v);
         COND_LE: res = z | (n != v);
         COND_AL: res = 1'b1;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

   // Architectural state
   logic [1:0] flags_nz_q, flags_nz_d;
   logic [1:0] flags_cv_q, flags_cv_d;
   logic       condex_dly_q, condex_dly_d;

   logic       condex;

   // Condition is always judged against the registered flags, never the
   // ALU's flags of the current cycle.
   assign condex = cond_eval(Cond, {flags_nz_q, flags_cv_q});

   // Next-state logic: the two flag groups load independently, and only
   // when the instruction actually executes.
   always_comb begin
      flags_nz_d   = flags_nz_q;
      flags_cv_d   = flags_cv_q;
      condex_dly_d = condex;
      if (FlagW[1] && condex) begin
         flags_nz_d = ALUFlags[3:2];
      end
      if (FlagW[0] && condex) begin
         flags_cv_d = ALUFlags[1:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flags_nz_q   <= 2'b00;
         flags_cv_q   <= 2'b00;
         condex_dly_q <= 1'b0;
      end else begin
         flags_nz_q   <= flags_nz_d;
         flags_cv_q   <= flags_cv_d;
         condex_dly_q <= condex_dly_d;
      end
   end

   // Write-enable gating. Strobes in the same cycle as a flag write still
   // see the pre-update decision through condex_dly_q. NextPC bypasses the
   // gate so fetch always advances.
   assign PCWrite  = (PCS & condex_dly_q) | NextPC;
   assign RegWrite = RegW & condex_dly_q;
   assign MemWrite = MemW & condex_dly_q;

`ifdef CONDLOGIC_FPU_EN
   assign FPUWrite = FPUW & condex_dly_q;
`else
   logic unused_fpuw;
   assign unused_fpuw = FPUW;
   assign FPUWrite    = 1'b0;
`endif

   assign Flags  = {flags_nz_q, flags_cv_q};
   assign CondEx = condex;

endmodule

// File: tb/tb_condlogic.sv
// -----------------------------------------------------------------------------
// tb_condlogic
//
// Directed stimulus for condlogic. Each stimulus step pushes its expected
// output vector into a queue; an independent monitor pops and compares on
// the falling clock edge.
// Output vector layout: {PCWrite, RegWrite, MemWrite, FPUWrite, Flags[3:0], CondEx}
// -----------------------------------------------------------------------------
module tb_condlogic;

   logic       clk;
   logic       reset;
   logic [3:0] Cond;
   logic [3:0] ALUFlags;
   logic [1:0] FlagW;
   logic       PCS;
   logic       NextPC;
   logic       RegW;
   logic       MemW;
   logic       FPUW;
   logic       PCWrite;
   logic       RegWrite;
   logic       MemWrite;
   logic       FPUWrite;
   logic [3:0] Flags;
   logic       CondEx;

`ifdef CONDLOGIC_FPU_EN
   localparam logic FPU_EXP = 1'b1;
`else
   localparam logic FPU_EXP = 1'b0;
`endif

   condlogic dut (
      .clk      (clk),
      .reset    (reset),
      .Cond     (Cond),
      .ALUFlags (ALUFlags),
      .FlagW    (FlagW),
      .PCS      (PCS),
      .NextPC   (NextPC),
      .RegW     (RegW),
      .MemW     (MemW),
      .FPUW     (FPUW),
      .PCWrite  (PCWrite),
      .RegWrite (RegWrite),
      .MemWrite (MemWrite),
      .FPUWrite (FPUWrite),
      .Flags    (Flags),
      .CondEx   (CondEx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [8:0] exp;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Monitor: compare against the oldest outstanding expectation.
   always @(negedge clk) begin
      while (q.size() > 0) begin
         exp_t       e;
         logic [8:0] act;
         e   = q.pop_front();
         act = {PCWrite, RegWrite, MemWrite, FPUWrite, Flags, CondEx};
         n_checks++;
         if (act === e.exp) begin
            n_pass++;
         end else begin
            $display("FAIL %s: got %b required %b (PCW RW MW FW NZCV CX)",
                     e.name, act, e.exp);
         end
      end
   end

   function automatic logic [8:0] ev(input logic pcw, input logic rw,
                                     input logic mw, input logic fw,
                                     input logic [3:0] f, input logic cx);
      return {pcw, rw, mw, fw, f, cx};
   endfunction

   task automatic push(input string name, input logic [8:0] exp);
      exp_t e;
      e.name = name;
      e.exp  = exp;
      q.push_back(e);
   endtask

   // Wait for the next rising edge, then drive a full input set.
   task automatic drive(input logic [3:0] c, input logic [3:0] af,
                        input logic [1:0] fw, input logic pcs,
                        input logic npc, input logic rw,
                        input logic mw, input logic fpw);
      @(posedge clk);
      #1;
      Cond     = c;
      ALUFlags = af;
      FlagW    = fw;
      PCS      = pcs;
      NextPC   = npc;
      RegW     = rw;
      MemW     = mw;
      FPUW     = fpw;
   endtask

   logic [3:0]  tf [4] = '{4'b0000, 4'b0110, 4'b1001, 4'b0010};
   logic [15:0] tt [4] = '{16'h56AA, 16'h66A5, 16'h565A, 16'h55A6};

   initial begin
      logic [3:0] cur;
      reset    = 1'b0;
      Cond     = 4'b1110;
      ALUFlags = 4'b0000;
      FlagW    = 2'b00;
      PCS      = 1'b0;
      NextPC   = 1'b0;
      RegW     = 1'b0;
      MemW     = 1'b0;
      FPUW     = 1'b0;

      // In reset: only NextPC reaches an enable; AL still evaluates true
      drive(4'b1110, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      push("reset_outputs", ev(1, 0, 0, 0, 4'b0000, 1));

      // Release reset; EQ on cleared flags fails
      drive(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      push("eq_clear_flags", ev(0, 0, 0, 0, 4'b0000, 0));

      // Flag write then EQ
      drive(4'b1110, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      push("flagw_al", ev(0, 0, 0, 0, 4'b0000, 1));
      drive(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      push("flags_0100_eq", ev(0, 0, 0, 0, 4'b0100, 1));
      drive(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      push("eq_regwrite", ev(0, 1, 0, 0, 4'b0100, 1));

      // Asynchronous reset mid-cycle kills in-flight RegWrite
      drive(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      #2;
      reset = 1'b0;
      push("async_reset", ev(0, 0, 0, 0, 4'b0000, 0));
      drive(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      push("eq_after_release", ev(0, 0, 0, 0, 4'b0000, 0));

      // Suppressed instruction: GT with N=1, V=0
      drive(4'b1110, 4'b1000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      push("load_1000", ev(0, 0, 0, 0, 4'b0000, 1));
      drive(4'b1100, 4'b0110, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      push("gt_fail", ev(0, 0, 0, 0, 4'b1000, 0));
      drive(4'b1100, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      push("gt_memwrite_blocked", ev(0, 0, 0, 0, 4'b1000, 0));

      // Partial flag groups
      drive(4'b1110, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      push("load_1111", ev(0, 0, 0, 0, 4'b1000, 1));
      drive(4'b1110, 4'b0000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      push("nz_only_write", ev(0, 0, 0, 0, 4'b1111, 1));
      drive(4'b1110, 4'b1100, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      push("flags_0011", ev(0, 0, 0, 0, 4'b0011, 1));
      drive(4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      push("cv_only_write", ev(0, 0, 0, 0, 4'b0000, 1));

      // Reserved condition and PC gating
      drive(4'b1111, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      push("nv_eval", ev(0, 0, 0, 0, 4'b0000, 0));
      drive(4'b1111, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      push("nv_pcs_blocked", ev(0, 0, 0, 0, 4'b0000, 0));
      drive(4'b1111, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      push("nextpc_override", ev(1, 0, 0, 0, 4'b0000, 0));
      drive(4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      push("al_eval", ev(0, 0, 0, 0, 4'b0000, 1));
      drive(4'b1110, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      push("al_pcs_write", ev(1, 0, 0, 0, 4'b0000, 1));
      drive(4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      push("fpu_write", ev(0, 0, 0, FPU_EXP, 4'b0000, 1));

      // Flag write and strobe in the same cycle use the pre-update decision
      drive(4'b0001, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      push("ne_eval", ev(0, 0, 0, 0, 4'b0000, 1));
      drive(4'b0001, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      push("ne_flagw_regw", ev(0, 1, 0, 0, 4'b0000, 1));
      drive(4'b0001, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      push("ne_delayed_hold", ev(0, 1, 0, 0, 4'b0100, 0));
      drive(4'b0001, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      push("ne_delayed_drop", ev(0, 0, 0, 0, 4'b0100, 0));

      // Full condition tables over several flag patterns
      cur = 4'b0100;
      for (int s = 0; s < 4; s++) begin
         drive(4'b1110, tf[s], 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         push($sformatf("load_%b", tf[s]), ev(0, 0, 0, 0, cur, 1));
         cur = tf[s];
         for (int c = 0; c < 16; c++) begin
            drive(c[3:0], 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            push($sformatf("cond_f%b_c%0d", cur, c),
                 ev(0, 0, 0, 0, cur, tt[s][c]));
         end
      end

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
      @(posedge clk);
      n_checks++;
      if (q.size() == 0) begin
         n_pass++;
      end else begin
         $display("FAIL drain: %0d expectations left, required 0", q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/condlogic.md
# condlogic

Conditional-execution stage of the multicycle core, directly downstream of the instruction decoder. Holds the NZCV status flags and evaluates the instruction's 4-bit condition field against them. It gates the decoder's raw write strobes (PCS, RegW, MemW, FPUW) into the architectural enables PCWrite, RegWrite, MemWrite and FPUWrite. The condition result is registered so the gate applies in the FSM cycles after the condition is evaluated.

## Interface
No parameters.
- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-low; low clears all state immediately
- Cond  input  4  instruction condition field, Instr[31:28]
- ALUFlags  input  4  {N,Z,C,V} from ALU, current cycle
- FlagW  input  2  decoder flag-write request; [1]=N,Z group, [0]=C,V group
- PCS  input  1  decoder: PC written by this instruction (branch or Rd=R15 write)
- NextPC  input  1  FSM: unconditional PC+4 update (fetch)
- RegW  input  1  FSM: register-file write request
- MemW  input  1  FSM: memory write request
- FPUW  input  1  FSM: FPU result write request
- PCWrite  output  1  PC register enable
- RegWrite  output  1  register-file write enable
- MemWrite  output  1  data-memory write enable
- FPUWrite  output  1  FPU register write enable
- Flags  output  4  current {N,Z,C,V} register contents
- CondEx  output  1  combinational condition result for the current cycle

## Operation
- Condition decode on Cond and the registered flags, producing CondEx (combinational):
  - EQ 0000: Z. NE 0001: !Z. CS 0010: C. CC 0011: !C.
  - MI 0100: N. PL 0101: !N. VS 0110: V. VC 0111: !V.
  - HI 1000: C&!Z. LS 1001: !C|Z. GE 1010: N==V. LT 1011: N!=V.
  - GT 1100: !Z&(N==V). LE 1101: Z|(N!=V). AL 1110: 1.
  - 1111: 0 (reserved; never executes).
- Flag registers:
  - NZ pair loads ALUFlags[3:2] when FlagW[1] & CondEx.
  - CV pair loads ALUFlags[1:0] when FlagW[0] & CondEx.
  - The two groups are independently enabled; otherwise the registers hold.
- CondExDelayed is a 1-bit register loaded with CondEx every clock.
- Output gating, all combinational from registered state:
  - PCWrite = (PCS & CondExDelayed) | NextPC
  - RegWrite = RegW & CondExDelayed
  - MemWrite = MemW & CondExDelayed
  - FPUWrite per Configuration.
- NextPC is never gated, so fetch proceeds regardless of condition.

## Timing
- Reset (reset=0, asynchronous): Flags=4'b0000 and CondExDelayed=0.
- Outputs during reset:
  - RegWrite=MemWrite=FPUWrite=0.
  - PCWrite=NextPC.
  - CondEx evaluated with all flags clear, e.g. Cond=AL gives 1 and Cond=EQ gives 0.
- Reset release is synchronous to the next rising edge; the first edge with reset=1 may load state.
- Flag-update latency is 1 cycle: flags written at edge k are visible on Flags and to CondEx after edge k.
- Write-enable latency is 1 cycle after the condition is evaluated.
  - The FSM evaluates Cond in its decode/execute cycle and asserts RegW/MemW/FPUW/PCS in later cycles.
  - The gate uses CondExDelayed, captured at the edge ending the evaluating cycle.
- CondExDelayed re-samples every cycle. The instruction register holds Cond and the flags are stable between instructions, so it is constant through an instruction's write-back.
- Simultaneous FlagW and a condition-dependent strobe in the same cycle: the strobe uses the pre-update flags via CondExDelayed; the new flags take effect from the next cycle.
- Simultaneous PCS=1 and NextPC=1: PCWrite=1 regardless of CondExDelayed.
- Reset asserted mid-instruction clears CondExDelayed, suppressing any in-flight RegWrite/MemWrite/FPUWrite in the same cycle.

## Configuration
Controlled by the macro `CONDLOGIC_FPU_EN`.
- Defined: FPUWrite = FPUW & CondExDelayed, and the condition result gates FP writes exactly as RegWrite.
- Undefined: FPUWrite tied to 0, and the FPUW input is ignored (for builds without the FPU).

## Test plan
- Reset, then flag gating:
  - Stimulus: assert reset=0 mid-cycle with RegW=1 and CondExDelayed=1.
  - Required: RegWrite drops to 0 immediately and Flags=0000.
  - Then: after release, Cond=EQ gives CondEx=0.
- Flag write and EQ:
  - Stimulus: Cond=AL, FlagW=11, ALUFlags=0100, one edge.
  - Required: Flags=0100.
  - Then: Cond=EQ gives CondEx=1, and the next cycle with RegW=1 gives RegWrite=1.
- Suppressed instruction:
  - Stimulus: Flags=0000, Cond=NE→ replace with Cond=GT while Flags=1000 (N=1, V=0).
  - Required: CondEx=0; FlagW=11 with ALUFlags=0110 leaves Flags=1000; MemW=1 next cycle gives MemWrite=0.
- Partial flag group:
  - Stimulus: Flags=1111, Cond=AL, FlagW=10, ALUFlags=0000.
  - Required: Flags=0011.
- Reserved and unconditional PC:
  - Stimulus: Cond=1111, PCS=1, NextPC=0.
  - Required: PCWrite=0 the following cycle; with NextPC=1, PCWrite=1 in that cycle.
- FPU macro:
  - Stimulus: Cond=AL, FPUW=1 next cycle.
  - Required: FPUWrite=1 with `CONDLOGIC_FPU_EN` defined, and FPUWrite=0 when undefined.
